// File: rtl/mini16_reset_pkg.sv
// Shared types and width helpers for the mini16 reset sequencer.
package mini16_reset_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  localparam int RESET_COUNT_W = 8;
  localparam logic [RESET_COUNT_W-1:0] RESET_COUNT_MAX = '1;

  // Bits needed for a down/up counter spanning 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int HOLD_CNT_W_DEFAULT     = cnt_width(1024);
  localparam int DEBOUNCE_CNT_W_DEFAULT = cnt_width(500000);

endpackage

// File: rtl/mini16_debounce.sv
// Synchroniser plus stability counter for a bouncing asynchronous level.
// dout resets to 1 (released) and follows din only after DEBOUNCE_CYCLES stable cycles.
module mini16_debounce
  import mini16_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [DB_W-1:0]        db_cnt_reg;
  logic                   dout_reg;
  logic                   din_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end
  end

  assign din_s = sync_reg[SYNC_STAGES-1];

  // Counts consecutive cycles where the synchronised level disagrees with dout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_reg   <= 1'b1;
      db_cnt_reg <= '0;
    end else if (din_s == dout_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      dout_reg   <= din_s;
      db_cnt_reg <= '0;
    end else begin
      db_cnt_reg <= db_cnt_reg + DB_W'(1);
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/mini16_reset_seq.sv
// Reset sequencer for mini16_soc: lock sync, post-lock hold, re-reset on lock loss.
// Optional button soft reset built when BTN_SOFT_RESET_EN is defined.
module mini16_reset_seq
  import mini16_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pll_locked,
  input  logic                     btn_n,
  output logic                     soc_reset,
  output logic                     ready,
  output logic [RESET_COUNT_W-1:0] reset_count
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0]   lock_sync_reg;
  logic                     locked_s;
  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [RESET_COUNT_W-1:0] count_reg, count_next;
  logic                     soc_reset_reg, soc_reset_next;
  logic                     ready_reg, ready_next;
  logic                     bump;
  logic                     soft_press;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_sync_reg <= '0;
    end else begin
      lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = lock_sync_reg[SYNC_STAGES-1];

`ifdef BTN_SOFT_RESET_EN
  logic btn_db;
  logic btn_db_prev_reg;

  mini16_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (btn_n),
    .dout  (btn_db)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_db_prev_reg <= 1'b1;
    end else begin
      btn_db_prev_reg <= btn_db;
    end
  end

  // Single-cycle strobe on the debounced falling edge, so a held button fires once.
  assign soft_press = btn_db_prev_reg & ~btn_db;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  logic unused_btn;
  assign unused_btn = btn_n;
  assign soft_press = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_WAIT_LOCK;
      cnt_reg       <= '0;
      count_reg     <= '0;
      soc_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      count_reg     <= count_next;
      soc_reset_reg <= soc_reset_next;
      ready_reg     <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    count_next = count_reg;
    bump       = 1'b0;

    case (state_reg)
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_next = S_HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          state_next = S_WAIT_LOCK;
        end else if (cnt_reg == '0) begin
          state_next = S_RUN;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_RUN: begin
        // Lock loss wins over a simultaneous button press.
        if (!locked_s) begin
          state_next = S_WAIT_LOCK;
          bump       = 1'b1;
        end else if (soft_press) begin
          state_next = S_HOLD;
          cnt_next   = HOLD_LOAD;
          bump       = 1'b1;
        end
      end
      default: state_next = S_WAIT_LOCK;
    endcase

    if (bump && (count_reg != RESET_COUNT_MAX)) begin
      count_next = count_reg + RESET_COUNT_W'(1);
    end

    // Outputs follow the next state so they change on the same edge as the FSM.
    soc_reset_next = (state_next != S_RUN);
    ready_next     = (state_next == S_RUN);
  end

  assign soc_reset   = soc_reset_reg;
  assign ready       = ready_reg;
  assign reset_count = count_reg;

endmodule
